// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: SPI slave that deserialises MOSI command frames and serialises RAM read data onto MISO
module spi_slave_ctrl #(
    parameter int FRAME_W = 10,
    parameter int DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
);
    localparam int CW = $clog2(FRAME_W + 1);
    localparam int TW = $clog2(DATA_W + 2);
    localparam logic [CW-1:0] LAST = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] FULL = CW'(FRAME_W);
    localparam logic [TW-1:0] TX_LOAD = TW'(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t             state, state_d;
    logic [FRAME_W-1:0] sr, sr_d, rx_data_d;
    logic [CW-1:0]      bit_cnt, bit_cnt_d;
    logic [DATA_W-1:0]  tx_sr, tx_sr_d;
    logic [TW-1:0]      tx_cnt, tx_cnt_d;
    logic               rd_addr_held, held_d, rx_valid_d, miso_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            sr           <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            miso         <= 1'b0;
            rd_addr_held <= 1'b0;
            tx_sr        <= '0;
            tx_cnt       <= '0;
        end else begin
            state        <= state_d;
            sr           <= sr_d;
            bit_cnt      <= bit_cnt_d;
            rx_data      <= rx_data_d;
            rx_valid     <= rx_valid_d;
            miso         <= miso_d;
            rd_addr_held <= held_d;
            tx_sr        <= tx_sr_d;
            tx_cnt       <= tx_cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        if (state == IDLE)
            state_d = ss_n ? IDLE : CHK_CMD;
        else if (ss_n)
            state_d = IDLE;
        else if (state == CHK_CMD)
            state_d = !mosi ? WRITE : rd_addr_held ? READ_DATA : READ_ADD;
    end

    // tx_cnt: 0 = waiting for RAM data, DATA_W+1..2 = shifting out, 1 = readout finished
    always_comb begin
        sr_d       = sr;
        bit_cnt_d  = bit_cnt;
        rx_data_d  = rx_data;
        rx_valid_d = 1'b0;
        miso_d     = 1'b0;
        held_d     = rd_addr_held;
        tx_sr_d    = tx_sr;
        tx_cnt_d   = tx_cnt;
        if (ss_n || state == IDLE) begin
            bit_cnt_d = '0;
            tx_cnt_d  = '0;
        end else if (state == CHK_CMD) begin
            sr_d      = {{(FRAME_W-1){1'b0}}, mosi};
            bit_cnt_d = CW'(1);
        end else if (bit_cnt != FULL) begin
            sr_d      = {sr[FRAME_W-2:0], mosi};
            bit_cnt_d = bit_cnt + 1'b1;
            if (bit_cnt == LAST) begin
                rx_data_d  = sr_d;
                rx_valid_d = 1'b1;
                held_d     = state == READ_ADD ? 1'b1 : state == READ_DATA ? 1'b0 : rd_addr_held;
            end
        end else if (state == READ_DATA) begin
            if (tx_cnt == '0 && tx_valid) begin
                tx_sr_d  = tx_data;
                tx_cnt_d = TX_LOAD;
            end else if (tx_cnt > TW'(1)) begin
                miso_d   = tx_sr[DATA_W-1];
                tx_sr_d  = {tx_sr[DATA_W-2:0], 1'b0};
                tx_cnt_d = tx_cnt - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: directed scenario bench for the SPI slave front end
module tb_spi_slave_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    spi_slave_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ss_n(ss_n), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [9:0] f);
        ss_n = 1'b0;
        tick;
        for (int i = 9; i >= 0; i--) begin
            mosi = f[i];
            tick;
            if (i > 0) begin
                vectors++;
                if (rx_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL early_valid frame %h bit %0d: rx_valid=%b want 0", f, i, rx_valid);
                end
            end
        end
        vectors++;
        if (rx_valid !== 1'b1 || rx_data !== f) begin
            miscompares++;
            $display("FAIL frame_done: rx_valid=%b rx_data=%h want 1 / %h", rx_valid, rx_data, f);
        end
        mosi = 1'b0;
        tick;
        vectors++;
        if (rx_valid !== 1'b0 || rx_data !== f) begin
            miscompares++;
            $display("FAIL valid_pulse: rx_valid=%b rx_data=%h want 0 / %h", rx_valid, rx_data, f);
        end
    endtask

    task automatic end_frame;
        ss_n = 1'b1;
        tick;
        vectors++;
        if (miso !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_miso: miso=%b want 0", miso);
        end
    endtask

    task automatic readout(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        tick;
        vectors++;
        if (miso !== 1'b0) begin
            miscompares++;
            $display("FAIL latch_miso: miso=%b want 0", miso);
        end
        tx_valid = 1'b0;
        tx_data = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            tick;
            vectors++;
            if (miso !== d[i]) begin
                miscompares++;
                $display("FAIL miso_bit%0d data %h: miso=%b want %b", i, d, miso, d[i]);
            end
        end
        tick;
        vectors++;
        if (miso !== 1'b0) begin
            miscompares++;
            $display("FAIL miso_after: miso=%b want 0", miso);
        end
    endtask

    task automatic check_quiet_miso(input int n);
        tx_data = 8'hFF;
        tx_valid = 1'b1;
        repeat (n) begin
            tick;
            vectors++;
            if (miso !== 1'b0) begin
                miscompares++;
                $display("FAIL quiet_miso: miso=%b want 0", miso);
            end
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        ss_n = 1'b1;
        tick;
        tick;
        vectors++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            miscompares++;
            $display("FAIL reset: miso=%b rx_valid=%b rx_data=%h want 0/0/000", miso, rx_valid, rx_data);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_write;
        send_frame(10'h0A5);
        mosi = 1'b1;
        repeat (12) begin
            tick;
            vectors++;
            if (rx_valid !== 1'b0 || rx_data !== 10'h0A5) begin
                miscompares++;
                $display("FAIL extra_bits: rx_valid=%b rx_data=%h want 0 / 0a5", rx_valid, rx_data);
            end
        end
        mosi = 1'b0;
        end_frame;
        send_frame(10'h13C);
        end_frame;
    endtask

    task automatic test_read;
        send_frame(10'h2A5);
        check_quiet_miso(6);
        end_frame;
        send_frame(10'h300);
        repeat (3) begin
            tick;
            vectors++;
            if (miso !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_miso: miso=%b want 0", miso);
            end
        end
        readout(8'h3C);
        check_quiet_miso(10);
        end_frame;
    endtask

    task automatic test_held_cleared;
        send_frame(10'h3FF);
        check_quiet_miso(10);
        end_frame;
        send_frame(10'h300);
        readout(8'h81);
        end_frame;
    endtask

    task automatic test_abort;
        logic [9:0] f;
        f = 10'h0F0;
        ss_n = 1'b0;
        tick;
        for (int i = 9; i >= 4; i--) begin
            mosi = f[i];
            tick;
        end
        ss_n = 1'b1;
        tick;
        vectors++;
        if (rx_valid !== 1'b0 || rx_data !== 10'h300 || miso !== 1'b0) begin
            miscompares++;
            $display("FAIL abort6: rx_valid=%b rx_data=%h miso=%b want 0 / 300 / 0", rx_valid, rx_data, miso);
        end
        send_frame(10'h155);
        end_frame;
        ss_n = 1'b0;
        tick;
        for (int i = 9; i >= 1; i--) begin
            mosi = f[i];
            tick;
        end
        mosi = f[0];
        ss_n = 1'b1;
        tick;
        vectors++;
        if (rx_valid !== 1'b0 || rx_data !== 10'h155) begin
            miscompares++;
            $display("FAIL abort_bit10: rx_valid=%b rx_data=%h want 0 / 155", rx_valid, rx_data);
        end
        tick;
        vectors++;
        if (rx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_late_valid: rx_valid=%b want 0", rx_valid);
        end
        send_frame(10'h2A5);
        end_frame;
    endtask

    task automatic test_reset_readout;
        logic [7:0] d;
        d = 8'hA5;
        send_frame(10'h300);
        tx_data = d;
        tx_valid = 1'b1;
        tick;
        tx_valid = 1'b0;
        for (int i = 7; i >= 3; i--) begin
            tick;
            vectors++;
            if (miso !== d[i]) begin
                miscompares++;
                $display("FAIL pre_reset_bit%0d: miso=%b want %b", i, miso, d[i]);
            end
        end
        rst_n = 1'b0;
        ss_n = 1'b1;
        tick;
        vectors++;
        if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin
            miscompares++;
            $display("FAIL mid_reset: miso=%b rx_valid=%b rx_data=%h want 0/0/000", miso, rx_valid, rx_data);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_reset_held;
        send_frame(10'h2A5);
        end_frame;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        send_frame(10'h3FF);
        check_quiet_miso(10);
        end_frame;
        send_frame(10'h300);
        readout(8'h81);
        end_frame;
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_held_cleared;
        test_abort;
        test_reset_readout;
        test_reset_held;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
